// File: rtl/alu_ctrl_seq.sv
// Fetch/execute sequencer for the 9-bit ALU: fetches over req/ack, decodes, owns C/Z flags and the PC.
// Optional retired-instruction counter is built only when ALU_CTRL_PERF_CNT_EN is defined.
module alu_ctrl_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [8:0]  i_instr,
    input  logic        i_imem_ack,
    input  logic        i_alu_sc_o,
    input  logic        i_alu_zero,
    output logic        o_imem_req,
    output logic [9:0]  o_pc,
    output logic [1:0]  o_Type,
    output logic [2:0]  o_M_op,
    output logic [1:0]  o_C_op,
    output logic [2:0]  o_A_op,
    output logic        o_V_op,
    output logic        o_sc_i,
    output logic [1:0]  o_ra_addr,
    output logic [1:0]  o_rb_addr,
    output logic [1:0]  o_wr_addr,
    output logic        o_wr_en,
    output logic        o_halted,
    output logic [15:0] o_retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_pc;
    logic [8:0]  r_instr;
    logic        r_c;
    logic        r_z;
    logic        r_imem_req;
    logic        r_halted;

    logic [1:0]  w_type;
    logic        w_is_math;
    logic        w_is_branch;
    logic        w_is_cmp;
    logic        w_is_mov;
    logic        w_is_halt;
    logic        w_flag_upd;
    logic        w_taken;
    logic [9:0]  w_offset;
    logic [9:0]  w_pc_next;

    assign w_type      = r_instr[8:7];
    assign w_is_math   = (w_type == 2'b00);
    assign w_is_branch = (w_type == 2'b01);
    assign w_is_cmp    = (w_type == 2'b10) && (r_instr[6:4] == 3'b100);
    assign w_is_mov    = (w_type == 2'b11) && !r_instr[6];
    assign w_is_halt   = (w_type == 2'b11) &&  r_instr[6];
    assign w_flag_upd  = w_is_math || w_is_cmp;

    // Branch condition uses the flags as committed before this EXEC cycle.
    always_comb begin
        w_taken = 1'b0;
        if (w_is_branch) begin
            case (r_instr[6:5])
                2'b00:   w_taken = r_z;
                2'b01:   w_taken = !r_z;
                2'b10:   w_taken = r_c;
                default: w_taken = 1'b1;
            endcase
        end
    end

    assign w_offset  = {{5{r_instr[4]}}, r_instr[4:0]};
    assign w_pc_next = w_taken ? (r_pc + w_offset) : (r_pc + 10'd1);

    always_comb begin
        w_next_state = r_state;
        o_Type       = 2'b00;
        o_M_op       = 3'b000;
        o_C_op       = 2'b00;
        o_A_op       = 3'b000;
        o_V_op       = 1'b0;
        o_sc_i       = 1'b0;
        o_ra_addr    = 2'b00;
        o_rb_addr    = 2'b00;
        o_wr_addr    = 2'b00;
        o_wr_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = w_is_halt ? S_HALT : S_FETCH;
                o_Type       = w_type;
                o_M_op       = w_is_math   ? r_instr[6:4] : 3'b000;
                o_C_op       = w_is_branch ? r_instr[6:5] : 2'b00;
                o_A_op       = (w_type == 2'b10) ? r_instr[6:4] : 3'b000;
                o_V_op       = (w_type == 2'b11) ? r_instr[6] : 1'b0;
                o_sc_i       = w_is_math ? r_c : 1'b0;
                o_ra_addr    = r_instr[3:2];
                o_rb_addr    = r_instr[1:0];
                o_wr_addr    = r_instr[3:2];
                o_wr_en      = w_is_math || w_is_mov;
            end
            default: begin
                w_next_state = S_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request and halted are registered from the next state so they line up with FETCH/HALT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc       <= 10'd0;
            r_instr    <= 9'd0;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_imem_req <= (w_next_state == S_FETCH);
            r_halted   <= (w_next_state == S_HALT);
            if ((r_state == S_FETCH) && i_imem_ack) begin
                r_instr <= i_instr;
            end
            if (r_state == S_EXEC) begin
                if (w_flag_upd) begin
                    r_c <= i_alu_sc_o;
                    r_z <= i_alu_zero;
                end
                if (!w_is_halt) begin
                    r_pc <= w_pc_next;
                end
            end
        end
    end

`ifdef ALU_CTRL_PERF_CNT_EN
    logic [15:0] r_retired_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_retired_cnt <= 16'd0;
        end else if ((r_state == S_EXEC) && (r_retired_cnt != 16'hFFFF)) begin
            r_retired_cnt <= r_retired_cnt + 16'd1;
        end
    end

    assign o_retired_cnt = r_retired_cnt;
`else
    assign o_retired_cnt = 16'd0;
`endif

    assign o_imem_req = r_imem_req;
    assign o_pc       = r_pc;
    assign o_halted   = r_halted;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Fetch/execute sequencer that drives the combinational ALU of the 9-bit processor. It fetches a 9-bit instruction over a req/ack handshake, decodes it into the ALU's `Type`/`M_op`/`C_op`/`A_op`/`V_op` fields and register-file addresses, and consumes the ALU's `sc_o`/`zero` outputs into carry/zero flags. It owns the carry flag fed back to the ALU's `sc_i`, resolves branches, and maintains the program counter.

## Interface
- No parameters. PC width is fixed at 10 bits; instruction width is fixed at 9 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  leaves IDLE when sampled high.
- `instr`  in  9  instruction word; valid when `imem_ack`=1.
- `imem_ack`  in  1  instruction memory acknowledge.
- `alu_sc_o`, `alu_zero`  in  1 each  ALU carry-out and zero outputs.
- `imem_req`  out  1  instruction fetch request.
- `pc`  out  10  fetch address.
- `Type`  out  2; `M_op`  out  3; `C_op`  out  2; `A_op`  out  3; `V_op`  out  1. These are the ALU control fields.
- `sc_i`  out  1  carry into ALU.
- `ra_addr`, `rb_addr`  out  2 each  register-file read addresses (ALU `inA`, `inB`).
- `wr_addr`  out  2; `wr_en`  out  1  register-file write port.
- `halted`  out  1  sequencer stopped.
- `retired_cnt`  out  16  retired-instruction count (see Configuration).

## Operation
- Instruction format: `[8:7]`=Type.
  - Type 00 Math: `[6:4]`=M_op, `[3:2]`=ra/rd, `[1:0]`=rb. Writes rd. Updates C and Z.
  - Type 01 Branch: `[6:5]`=C_op (00 BEQ Z=1, 01 BNE Z=0, 10 BCS C=1, 11 JMP always), `[4:0]`=signed offset.
  - Type 10 Assign: `[6:4]`=A_op, `[3:2]`=ra, `[1:0]`=rb. A_op 100 = CMP: updates C and Z, no write. All other A_op values are NOP.
  - Type 11 Value: `[6]`=V_op. V_op 0 = MOV rd(`[3:2]`) ← rb(`[1:0]`), with write and no flag change. V_op 1 = HALT.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE → FETCH on `start`.
  - FETCH: `imem_req`=1 and `pc` stable. On `imem_ack`=1, latch `instr` and go to EXEC.
  - EXEC (exactly one cycle): decoded fields drive the outputs, and writeback/flags/PC commit at the end of the cycle. Next state is FETCH, or HALT for HALT.
  - HALT is terminal until `reset`; `start` is ignored.
- `sc_i` = C flag for Math, and 0 for CMP.
- `wr_en`=1 only in EXEC of Math or MOV. `wr_addr` = `instr[3:2]`.
- `ra_addr`/`rb_addr` come from the latched instr in EXEC and are 0 otherwise. ALU field outputs are 0 outside EXEC.
- Next PC: taken branch = pc + sign_extend(offset) mod 1024; otherwise pc+1 mod 1024 (1023 wraps to 0). HALT leaves pc unchanged.
- `imem_ack` outside FETCH is ignored.

## Timing
- Reset values: FSM=IDLE; `pc`=0; C=Z=0; `imem_req`=0; `wr_en`=0; `halted`=0; `retired_cnt`=0; all field/address outputs 0.
- Minimum 2 cycles per instruction: 1 FETCH cycle when ack arrives in the first request cycle, plus 1 EXEC cycle. Each extra wait cycle before ack adds 1 cycle.
- `imem_req` is registered: high from the first FETCH cycle through the ack cycle, then low in EXEC.
- The branch condition uses the flags as they stand at the start of EXEC. A CMP immediately followed by BEQ sees the CMP's result.
- Reset asserted mid-FETCH or mid-EXEC: outputs go to reset values without waiting for a clock edge. No writeback occurs.
- `halted`=1 from the cycle after the HALT EXEC.

## Configuration
- `ALU_CTRL_PERF_CNT_EN` defined: `retired_cnt` increments by 1 at each EXEC cycle, including NOP and HALT, and saturates at 0xFFFF.
- Macro undefined: no counter logic is built, and `retired_cnt` is tied to 0.

## Test plan
- Reset, then pulse `start`. Present ADD r1,r2 (`9'b00_000_01_10`) with ack two cycles late. Required: `imem_req` high for 3 cycles; then one EXEC cycle with Type=00, M_op=000, ra_addr=1, rb_addr=2, wr_addr=1, wr_en=1, `sc_i`=0; `pc` goes 0→1.
- CMP with alu_zero=1 and alu_sc_o=1, then BEQ offset -3 (`5'b11101`) at pc=5. Required: pc becomes 2. Repeating with BNE gives pc=6. BCS is taken.
- `pc`=1022 with JMP offset +5. Required: pc=3. A non-branch at pc=1023 gives pc=0.
- HALT (`9'b11_1_000000`). Required: `halted`=1 and `imem_req` stays 0; pc is frozen over 10 cycles with `start` pulsed; asserting `reset` returns pc=0, `halted`=0, IDLE.
- Assert `reset` asynchronously mid-FETCH with `imem_req`=1 and flags set. Required: `imem_req`, C and Z drop to 0 before the next clock edge.
- With `ALU_CTRL_PERF_CNT_EN`, run ADD, NOP, HALT. Required: `retired_cnt`=3. Without the macro, `retired_cnt`=0 throughout.
